tt_islam_ihfaz_logic_unit: RTL and testbench

Parametrised, registered bitwise logic unit that generalises the single-bit NAND tile to a WIDTH-bit datapath with eight selectable operations, a valid/ready handshake, an accumulate mode and status flags. It sits behind the Tiny Tapeout pin wrapper: operands and opcode come from `ui_in`/`uio_in`, and results drive `uo_out`.

---
 rtl/tt_islam_ihfaz_logic_unit.sv | 75 +++++++
 tb/tb_tt_islam_ihfaz_logic_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tt_islam_ihfaz_logic_unit.sv
// Registered WIDTH-bit logic unit: eight bitwise ops, optional accumulator operand, flags, saturating op counter.
// One-cycle latency, full throughput; a held result (out_valid && !out_ready) stalls the input side.
module tt_islam_ihfaz_logic_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ones,
  output logic [CNT_W-1:0] op_count
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] res;
  logic             accept;

  // Clear blocks intake so a clear can never race an accumulator update.
  assign in_ready = !rst && !clr && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign opa      = acc_mode ? acc : a;

  always_comb begin
    res = '0;
    case (op)
      3'd0:    res = ~(opa & b);
      3'd1:    res = opa & b;
      3'd2:    res = opa | b;
      3'd3:    res = ~(opa | b);
      3'd4:    res = opa ^ b;
      3'd5:    res = ~(opa ^ b);
      3'd6:    res = ~opa;
      default: res = opa;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b1;
      ones      <= 1'b0;
      acc       <= '0;
      op_count  <= '0;
    end else begin
      if (clr) begin
        acc      <= '0;
        op_count <= '0;
      end
      if (accept) begin
        out_valid <= 1'b1;
        y         <= res;
        zero      <= (res == '0);
        ones      <= &res;
        acc       <= res;
        if (op_count != '1)
          op_count <= op_count + CNT_W'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tt_islam_ihfaz_logic_unit.sv
// Bench for tt_islam_ihfaz_logic_unit: vector table plus scoreboard of expected results.
// A second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_tt_islam_ihfaz_logic_unit;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid, acc_mode, out_ready;
  logic [2:0] op;
  logic [7:0] a, b;
  logic       in_ready, out_valid, zero, ones;
  logic [7:0] y, op_count;
  logic       in_ready2, out_valid2, zero2, ones2;
  logic [7:0] y2;
  logic [1:0] op_count2;

  always #5 clk = ~clk;

  tt_islam_ihfaz_logic_unit #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .acc_mode(acc_mode), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .zero(zero), .ones(ones), .op_count(op_count)
  );

  tt_islam_ihfaz_logic_unit #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready2),
    .op(op), .acc_mode(acc_mode), .a(a), .b(b), .out_valid(out_valid2),
    .out_ready(out_ready), .y(y2), .zero(zero2), .ones(ones2), .op_count(op_count2)
  );

  typedef struct {
    logic [7:0] y;
    logic       zero;
    logic       ones;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic       acc_mode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
  } vec_t;

  exp_t       q[$];
  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] cnt_m = 0;
  logic [1:0] cnt2_m = 0;
  vec_t       vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Results are consumed on the edge after a negedge that sees out_valid && out_ready.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL sb_empty: got result y=%h expected none at %0t", y, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_y", 32'(y), 32'(e.y));
        chk("sb_zero", 32'(zero), 32'(e.zero));
        chk("sb_ones", 32'(ones), 32'(e.ones));
        chk("sb_count", 32'(op_count), 32'(e.cnt));
        chk("sb_count_sat", 32'(op_count2), 32'(e.cnt2));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] o, input logic am, input logic [7:0] av,
                      input logic [7:0] bv, input logic [7:0] ey);
    bit ok = 0;
    exp_t e;
    op = o; acc_mode = am; a = av; b = bv; in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        cnt_m  = (cnt_m == 8'hFF) ? cnt_m : cnt_m + 8'd1;
        cnt2_m = (cnt2_m == 2'd3) ? cnt2_m : cnt2_m + 2'd1;
        e.y = ey; e.zero = (ey == 8'h00); e.ones = (ey == 8'hFF);
        e.cnt = cnt_m; e.cnt2 = cnt2_m;
        q.push_back(e);
        ok = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles, op %0d", o);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    cnt_m = 0; cnt2_m = 0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_ones", 32'(ones), 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{3'd0, 1'b0, 8'hF0, 8'hCC, 8'h3F};
    vecs[1] = '{3'd1, 1'b0, 8'hF0, 8'hCC, 8'hC0};
    vecs[2] = '{3'd2, 1'b0, 8'hF0, 8'hCC, 8'hFC};
    vecs[3] = '{3'd3, 1'b0, 8'hF0, 8'hCC, 8'h03};
    vecs[4] = '{3'd4, 1'b0, 8'hF0, 8'hCC, 8'h3C};
    vecs[5] = '{3'd5, 1'b0, 8'hF0, 8'hCC, 8'hC3};
    vecs[6] = '{3'd6, 1'b0, 8'hF0, 8'hCC, 8'h0F};
    vecs[7] = '{3'd7, 1'b0, 8'hF0, 8'hCC, 8'hF0};
    vecs[8] = '{3'd1, 1'b0, 8'h00, 8'hFF, 8'h00};
    vecs[9] = '{3'd0, 1'b0, 8'h00, 8'hFF, 8'hFF};

    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; acc_mode = 1'b0;
    out_ready = 1'b1; op = 3'd0; a = 8'h00; b = 8'h00;
    @(posedge clk); #1;
    do_reset();

    // Back-to-back opcode sweep then flag vectors; out_valid must never drop.
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].op, vecs[i].acc_mode, vecs[i].a, vecs[i].b, vecs[i].y);
      chk("sweep_out_valid", 32'(out_valid), 32'd1);
      if (i == 7) chk("sweep_count8", 32'(op_count), 32'd8);
    end

    // Backpressure: stall three cycles with a second transaction waiting.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(3'd2, 1'b0, 8'h12, 8'h21, 8'h33);
    op = 3'd1; acc_mode = 1'b0; a = 8'hFF; b = 8'h0F; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_y_held", 32'(y), 32'h33);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(3'd1, 1'b0, 8'hFF, 8'h0F, 8'h0F);
    @(negedge clk);
    chk("bp_second_valid", 32'(out_valid), 32'd1);
    chk("bp_second_y", 32'(y), 32'h0F);
    @(posedge clk); #1;

    // Accumulate chain, then clear.
    do_reset();
    send(3'd2, 1'b1, 8'hAA, 8'h0F, 8'h0F);
    send(3'd4, 1'b1, 8'hAA, 8'hFF, 8'hF0);
    send(3'd7, 1'b1, 8'h5A, 8'h00, 8'hF0);
    @(posedge clk); #1;
    clr = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    cnt_m = 0; cnt2_m = 0;
    @(negedge clk);
    chk("clr_count", 32'(op_count), 32'd0);
    chk("clr_y_kept", 32'(y), 32'hF0);
    @(posedge clk); #1;
    send(3'd7, 1'b1, 8'h55, 8'h00, 8'h00);
    @(negedge clk);
    chk("clr_count_after", 32'(op_count), 32'd1);
    @(posedge clk); #1;

    // Saturation on the 2-bit counter instance: 1,2,3,3,3 via scoreboard.
    do_reset();
    for (int i = 0; i < 5; i++) send(3'd1, 1'b0, 8'h0F, 8'h3C, 8'h0C);
    @(negedge clk);
    chk("sat_final", 32'(op_count2), 32'd3);
    @(posedge clk); #1;

    // Reset while a result is stalled.
    out_ready = 1'b0;
    send(3'd1, 1'b0, 8'hFF, 8'h3C, 8'h3C);
    @(negedge clk);
    chk("mid_pending", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    do_reset();
    out_ready = 1'b1;
    send(3'd7, 1'b1, 8'h77, 8'h00, 8'h00);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
